// File: rtl/rs_dispatch.sv
// rs_dispatch: reservation station, oldest-ready dispatch to a shared unit; RS_CDB_BYPASS_EN forwards the CDB into same-cycle dispatch
module rs_dispatch #(
  parameter int RS_DEPTH = 4,
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 6
) (
  input  logic       clk1,
  input  logic       rst,
  input  logic       issue_v,
  output logic       issue_ready,
  input  logic [3:0] issue_func,
  input  logic [3:0] issue_rd,
  input  logic [2:0] issue_rob,
  input  logic       issue_qj_v,
  input  logic [2:0] issue_qj,
  input  logic [7:0] issue_vj,
  input  logic       issue_qk_v,
  input  logic [2:0] issue_qk,
  input  logic [7:0] issue_vk,
  input  logic       cdb_v,
  input  logic [2:0] cdb_rob,
  input  logic [7:0] cdb_data,
  output logic       exec_b,
  output logic [7:0] rs1_data,
  output logic [7:0] rs2_data,
  output logic [3:0] func,
  output logic [2:0] rob_ind,
  output logic [3:0] rd,
  output logic [3:0] occupancy
);
  localparam int IW = $clog2(RS_DEPTH);
  logic [RS_DEPTH-1:0] val, qj_p, qk_p, hj, hk, rdy;
  logic [2:0] qj [RS_DEPTH];
  logic [2:0] qk [RS_DEPTH];
  logic [7:0] vj [RS_DEPTH];
  logic [7:0] vk [RS_DEPTH];
  logic [3:0] fn [RS_DEPTH];
  logic [3:0] rdr [RS_DEPTH];
  logic [2:0] rb [RS_DEPTH];
  // age = number of older valid entries; the oldest has age 0
  logic [2:0] age [RS_DEPTH];
  logic [7:0] busy;
  logic [3:0] occ;
  logic [IW-1:0] sel, fr;
  logic [2:0] best;
  logic sel_v, disp, iss;
  logic [7:0] dj, dk;
  function automatic logic [7:0] lat_m1(logic [3:0] f);
    return f <= 4'd1 ? 8'(ADD_LAT - 1) : f == 4'd2 ? 8'(MUL_LAT - 1) :
           f == 4'd3 ? 8'(DIV_LAT - 1) : 8'd0;
  endfunction
  assign occupancy = occ;
  assign issue_ready = occ < 4'(RS_DEPTH);
  assign iss = issue_v && issue_ready;
  assign disp = sel_v && busy == 8'd0;
  always_comb begin
    sel_v = 1'b0;
    sel = '0;
    best = '0;
    fr = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      hj[i] = val[i] && qj_p[i] && cdb_v && qj[i] == cdb_rob;
      hk[i] = val[i] && qk_p[i] && cdb_v && qk[i] == cdb_rob;
`ifdef RS_CDB_BYPASS_EN
      rdy[i] = val[i] && (!qj_p[i] || hj[i]) && (!qk_p[i] || hk[i]);
`else
      rdy[i] = val[i] && !qj_p[i] && !qk_p[i];
`endif
      if (rdy[i] && (!sel_v || age[i] < best)) begin
        sel_v = 1'b1;
        sel = IW'(i);
        best = age[i];
      end
    end
    for (int i = RS_DEPTH - 1; i >= 0; i--)
      if (!val[i]) fr = IW'(i);
`ifdef RS_CDB_BYPASS_EN
    dj = hj[sel] ? cdb_data : vj[sel];
    dk = hk[sel] ? cdb_data : vk[sel];
`else
    dj = vj[sel];
    dk = vk[sel];
`endif
  end
  always_ff @(posedge clk1) begin
    if (rst) begin
      val <= '0;
      busy <= '0;
      occ <= '0;
      exec_b <= 1'b0;
      rs1_data <= '0;
      rs2_data <= '0;
      func <= '0;
      rob_ind <= '0;
      rd <= '0;
    end else begin
      exec_b <= disp;
      if (disp) begin
        rs1_data <= dj;
        rs2_data <= dk;
        func <= fn[sel];
        rob_ind <= rb[sel];
        rd <= rdr[sel];
        busy <= lat_m1(fn[sel]);
      end else if (busy != 8'd0) begin
        busy <= busy - 8'd1;
      end
      occ <= occ + 4'(iss) - 4'(disp);
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (hj[i]) begin
          vj[i] <= cdb_data;
          qj_p[i] <= 1'b0;
        end
        if (hk[i]) begin
          vk[i] <= cdb_data;
          qk_p[i] <= 1'b0;
        end
        if (disp && sel == IW'(i)) val[i] <= 1'b0;
        if (disp && val[i] && age[i] > best) age[i] <= age[i] - 3'd1;
      end
      if (iss) begin
        val[fr] <= 1'b1;
        fn[fr] <= issue_func;
        rdr[fr] <= issue_rd;
        rb[fr] <= issue_rob;
        qj[fr] <= issue_qj;
        qk[fr] <= issue_qk;
        qj_p[fr] <= issue_qj_v && !(cdb_v && cdb_rob == issue_qj);
        qk_p[fr] <= issue_qk_v && !(cdb_v && cdb_rob == issue_qk);
        vj[fr] <= issue_qj_v ? cdb_data : issue_vj;
        vk[fr] <= issue_qk_v ? cdb_data : issue_vk;
        age[fr] <= 3'(occ - 4'(disp));
      end
    end
  end
endmodule

// File: tb/tb_rs_dispatch.sv
// tb_rs_dispatch: random and directed stimulus against an ordered-queue model of the station
module tb_rs_dispatch;
  localparam int D = 4;
`ifdef RS_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk1 = 1'b0, rst = 1'b1;
  logic issue_v = 1'b0, issue_ready, issue_qj_v = 1'b0, issue_qk_v = 1'b0, cdb_v = 1'b0;
  logic [3:0] issue_func = '0, issue_rd = '0;
  logic [2:0] issue_rob = '0, issue_qj = '0, issue_qk = '0, cdb_rob = '0;
  logic [7:0] issue_vj = '0, issue_vk = '0, cdb_data = '0;
  logic exec_b;
  logic [7:0] rs1_data, rs2_data;
  logic [3:0] func, rd, occupancy;
  logic [2:0] rob_ind;
  always #5 clk1 = ~clk1;
  rs_dispatch dut (
    .clk1(clk1), .rst(rst), .issue_v(issue_v), .issue_ready(issue_ready),
    .issue_func(issue_func), .issue_rd(issue_rd), .issue_rob(issue_rob),
    .issue_qj_v(issue_qj_v), .issue_qj(issue_qj), .issue_vj(issue_vj),
    .issue_qk_v(issue_qk_v), .issue_qk(issue_qk), .issue_vk(issue_vk),
    .cdb_v(cdb_v), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
    .exec_b(exec_b), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .func(func), .rob_ind(rob_ind), .rd(rd), .occupancy(occupancy)
  );
  typedef struct {
    logic [3:0] f, rd;
    logic [2:0] rob, qj, qk;
    logic qjv, qkv;
    logic [7:0] vj, vk;
  } ent_t;
  ent_t q[$];
  int tests = 0, fails = 0, n = 0, free_at = 0;
  logic m_exec = 1'b0;
  logic [7:0] m_r1 = '0, m_r2 = '0;
  logic [3:0] m_f = '0, m_rd = '0;
  logic [2:0] m_rob = '0;
  function automatic int lat(logic [3:0] f);
    return f <= 4'd1 ? 2 : f == 4'd2 ? 4 : f == 4'd3 ? 6 : 1;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask
  // the model is the queue in issue order; the unit is free once free_at is reached
  task automatic model;
    if (rst) begin
      q.delete();
      {m_exec, m_r1, m_r2, m_f, m_rd, m_rob} = '0;
      free_at = 0;
    end else begin
      bit cap = q.size() < D;
      int s = -1;
      ent_t e;
      if (n >= free_at)
        for (int i = 0; i < q.size(); i++)
          if (s < 0 && (!q[i].qjv || (BYP && cdb_v && q[i].qj == cdb_rob)) &&
              (!q[i].qkv || (BYP && cdb_v && q[i].qk == cdb_rob))) s = i;
      m_exec = s >= 0;
      if (s >= 0) begin
        e = q[s];
        m_r1 = e.qjv ? cdb_data : e.vj;
        m_r2 = e.qkv ? cdb_data : e.vk;
        m_f = e.f;
        m_rd = e.rd;
        m_rob = e.rob;
        free_at = n + lat(e.f);
        q.delete(s);
      end
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        if (cdb_v && e.qjv && e.qj == cdb_rob) begin e.vj = cdb_data; e.qjv = 0; end
        if (cdb_v && e.qkv && e.qk == cdb_rob) begin e.vk = cdb_data; e.qkv = 0; end
        q[i] = e;
      end
      if (issue_v && cap) begin
        e.f = issue_func; e.rd = issue_rd; e.rob = issue_rob;
        e.qj = issue_qj; e.qk = issue_qk;
        e.qjv = issue_qj_v && !(cdb_v && cdb_rob == issue_qj);
        e.qkv = issue_qk_v && !(cdb_v && cdb_rob == issue_qk);
        e.vj = issue_qj_v ? cdb_data : issue_vj;
        e.vk = issue_qk_v ? cdb_data : issue_vk;
        q.push_back(e);
      end
    end
  endtask
  task automatic step;
    @(posedge clk1);
    model();
    n++;
    @(negedge clk1);
    check("exec_b", 32'(exec_b), 32'(m_exec));
    check("occupancy", 32'(occupancy), 32'(q.size()));
    check("issue_ready", 32'(issue_ready), 32'(q.size() < D));
    check("rs1_data", 32'(rs1_data), 32'(m_r1));
    check("rs2_data", 32'(rs2_data), 32'(m_r2));
    check("func", 32'(func), 32'(m_f));
    check("rob_ind", 32'(rob_ind), 32'(m_rob));
    check("rd", 32'(rd), 32'(m_rd));
  endtask
  task automatic idle;
    issue_v = 0; issue_qj_v = 0; issue_qk_v = 0; cdb_v = 0;
  endtask
  task automatic issue(input logic [3:0] f, input logic [3:0] r, input logic [2:0] rob,
                       input logic jv, input logic [2:0] tj, input logic [7:0] vj,
                       input logic kv, input logic [2:0] tk, input logic [7:0] vk);
    issue_v = 1; issue_func = f; issue_rd = r; issue_rob = rob;
    issue_qj_v = jv; issue_qj = tj; issue_vj = vj;
    issue_qk_v = kv; issue_qk = tk; issue_vk = vk;
  endtask
  task automatic bcast(input logic [2:0] t, input logic [7:0] d);
    cdb_v = 1; cdb_rob = t; cdb_data = d;
  endtask
  initial begin
    @(negedge clk1);
    step(); step();
    rst = 0;
    issue(4'd0, 4'd3, 3'd1, 0, 3'd0, 8'd5, 0, 3'd0, 8'd7); step();
    idle(); repeat (3) step();
    issue(4'd2, 4'd4, 3'd3, 1, 3'd2, 8'd0, 0, 3'd0, 8'd4); step();
    idle(); step();
    bcast(3'd2, 8'd9); step();
    idle(); repeat (6) step();
    issue(4'd3, 4'd1, 3'd4, 0, 3'd0, 8'd11, 0, 3'd0, 8'd12); step();
    idle(); step();
    issue(4'd0, 4'd2, 3'd5, 0, 3'd0, 8'd13, 0, 3'd0, 8'd14); step();
    idle(); repeat (8) step();
    for (int k = 0; k < 5; k++) begin
      issue(4'(k % 4), 4'(k), 3'(k), 1, 3'd5, 8'd0, 0, 3'd0, 8'(k + 20)); step();
    end
    idle(); bcast(3'd5, 8'h5A); step();
    idle(); repeat (20) step();
    issue(4'd1, 4'd6, 3'd6, 1, 3'd6, 8'd0, 0, 3'd0, 8'h55); bcast(3'd6, 8'hAA); step();
    idle(); repeat (4) step();
    issue(4'd3, 4'd7, 3'd0, 0, 3'd0, 8'd1, 0, 3'd0, 8'd2); step();
    for (int k = 0; k < 3; k++) begin
      issue(4'd0, 4'(k), 3'(k), 1, 3'd7, 8'd0, 1, 3'd7, 8'd0); step();
    end
    idle(); rst = 1; step();
    rst = 0; bcast(3'd7, 8'h77); step();
    idle(); repeat (5) step();
    for (int c = 0; c < 3000; c++) begin
      issue_v = $urandom_range(0, 1);
      issue_func = 4'($urandom_range(0, 5)); issue_rd = 4'($urandom); issue_rob = 3'($urandom);
      issue_qj_v = $urandom_range(0, 1); issue_qj = 3'($urandom); issue_vj = 8'($urandom);
      issue_qk_v = $urandom_range(0, 1); issue_qk = 3'($urandom); issue_vk = 8'($urandom);
      cdb_v = $urandom_range(0, 9) < 4; cdb_rob = 3'($urandom); cdb_data = 8'($urandom);
      rst = $urandom_range(0, 199) == 0;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
